aux_clk_ctrl: RTL and testbench
===============================

AUX_CLK_CTRL -- requirements
Module: aux_clk_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16, number of consecutive stable cycles required to accept a new sw_en level.
REQ-002 Parameter LOCK_EDGES, default 8, number of aux_tgl edges (rising plus falling) required to declare the aux clock alive.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum number of WAIT_LOCK cycles before failure.
REQ-004 Parameter WINDOW_CYCLES, default 64, watchdog window in RUN (used only with AUX_CLK_WATCHDOG_EN).
REQ-005 clk  input  1  system clock (50 MHz); the block's single clock.
REQ-006 nrst  input  1  reset, asynchronous, active-low.
REQ-007 sw_en  input  1  asynchronous switch request to run the aux clock.
REQ-008 aux_tgl  input  1  asynchronous toggle bit generated in the aux (27 MHz) domain, e.g. a divided-counter bit.
REQ-009 sel_clk_aux  output  1  enable for the external aux oscillator.
REQ-010 aux_ok  output  1  aux clock locked and running.
REQ-011 aux_fail  output  1  aux clock failed to start, or stopped.
REQ-012 state_o  output  3  current FSM state code, for LED and debug.

Function
REQ-013 sw_en and aux_tgl SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 The debounced switch sw_deb SHALL take the synchronized sw_en value only after that value differs from sw_deb for DEB_CYCLES consecutive cycles; any reversion restarts the count.
REQ-015 An aux edge SHALL be detected when the synchronized aux_tgl differs from its value on the previous cycle.
REQ-016 FSM states and codes: OFF=0, START=1, WAIT_LOCK=2, RUN=3, FAIL=4; state_o SHALL equal the registered state code.
REQ-017 OFF: sel_clk_aux=0; when sw_deb=1, go to START.
REQ-018 START: sel_clk_aux=1; clear the edge and timeout counters; go to WAIT_LOCK after exactly 1 cycle.
REQ-019 WAIT_LOCK: sel_clk_aux=1; count edges (saturating) and cycles.
- Reaching LOCK_EDGES edges -> RUN.
- Otherwise, on the TIMEOUT_CYCLES-th cycle in WAIT_LOCK -> FAIL.
- Lock and timeout in the same cycle: lock wins.
REQ-020 RUN: sel_clk_aux=1, aux_ok=1.
REQ-021 FAIL: sel_clk_aux=0, aux_fail=1; FAIL is held until sw_deb=0, then the FSM goes to OFF.
REQ-022 sw_deb=0 in START, WAIT_LOCK or RUN SHALL force OFF on the next cycle, with priority over every other transition.
REQ-023 All outputs SHALL be registered and decoded from the state, with aux_ok and aux_fail never asserted together.
REQ-024 Counter widths SHALL be $clog2(param)+1; all counters SHALL saturate and never wrap.

Reset
REQ-025 While nrst=0: state=OFF, all counters, synchronizer flops and sw_deb = 0, and sel_clk_aux = aux_ok = aux_fail = 0, state_o = 0.
REQ-026 Reset assertion SHALL take effect asynchronously mid-operation; release is sampled on clk.

Configuration
REQ-027 With AUX_CLK_WATCHDOG_EN defined, RUN SHALL keep a window counter that clears on every aux edge; reaching WINDOW_CYCLES cycles without an edge -> FAIL.
REQ-028 Without AUX_CLK_WATCHDOG_EN, there SHALL be no window counter, and RUN SHALL be left only via sw_deb=0 or reset.

Structure
REQ-029 A shared package aux_clk_pkg SHALL hold the state enum (3-bit) and the default parameter constants.
REQ-030 The synchronizer plus debouncer SHALL be a sub-module, sync_debounce (parameter DEB_CYCLES), instantiated for sw_en; aux_tgl uses a plain 2-flop synchronizer.

Verification (defaults; aux_tgl toggles every 3 clk cycles unless stated)
REQ-031 nrst=0, sw_en=1 for 100 cycles -> sel_clk_aux=0, state_o=0 throughout.
REQ-032 Release reset, then sw_en 0->1 -> sel_clk_aux=1 between 18 and 20 cycles after the rise; aux_ok=1 after 8 detected edges; state_o=3.
REQ-033 aux_tgl held 0 after START -> aux_fail=1, sel_clk_aux=0, state_o=4 exactly 1024 cycles after WAIT_LOCK entry; sw_en=0 -> OFF after debounce.
REQ-034 sw_en pulse of 5 cycles in OFF -> no state change; a pulse of 5 cycles low in RUN -> RUN is kept.
REQ-035 In RUN, stop aux_tgl -> with AUX_CLK_WATCHDOG_EN, FAIL 64 cycles after the last edge; without the macro, the FSM stays in RUN.
REQ-036 nrst=0 mid WAIT_LOCK -> all outputs 0 before the next clk edge; after release the FSM relocks from OFF.

Source files
------------

// File: rtl/aux_clk_pkg.sv
// Shared types and default constants for the aux clock controller.
package aux_clk_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } aux_state_e;

    localparam int unsigned DEF_DEB_CYCLES     = 16;
    localparam int unsigned DEF_LOCK_EDGES     = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
    localparam int unsigned DEF_WINDOW_CYCLES  = 64;

    // Counter width able to hold the terminal value n itself.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// 2-flop synchronizer followed by a debouncer: the output follows the
// synchronized input only after it has differed for DEB_CYCLES consecutive cycles.
module sync_debounce
    import aux_clk_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic dout
);

    localparam int unsigned     CW       = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the input agrees with the debounced value restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q >= CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/aux_clk_ctrl.sv
// Aux oscillator enable/lock controller. Optional RUN-state activity
// watchdog is built when AUX_CLK_WATCHDOG_EN is defined.
module aux_clk_ctrl
    import aux_clk_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int unsigned LOCK_EDGES     = DEF_LOCK_EDGES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned WINDOW_CYCLES  = DEF_WINDOW_CYCLES
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       sw_en,
    input  logic       aux_tgl,
    output logic       sel_clk_aux,
    output logic       aux_ok,
    output logic       aux_fail,
    output logic [2:0] state_o
);

    localparam int unsigned   EW       = cnt_w(LOCK_EDGES);
    localparam int unsigned   TW       = cnt_w(TIMEOUT_CYCLES);
    localparam logic [EW-1:0] EDGE_MAX = EW'(LOCK_EDGES);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    logic          sw_deb;
    logic          aux_s1_q, aux_s2_q, aux_prev_q;
    logic          aux_edge;
    aux_state_e    state_q, state_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          sel_q, sel_d, ok_q, ok_d, fail_q, fail_d;

`ifdef AUX_CLK_WATCHDOG_EN
    localparam int unsigned   WW      = cnt_w(WINDOW_CYCLES);
    localparam logic [WW-1:0] WIN_MAX = WW'(WINDOW_CYCLES);
    logic [WW-1:0] win_cnt_q, win_cnt_d;
`else
    logic unused_window;
    assign unused_window = ^32'(WINDOW_CYCLES);
`endif

    sync_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_sw_deb (
        .clk  (clk),
        .nrst (nrst),
        .din  (sw_en),
        .dout (sw_deb)
    );

    assign aux_edge = aux_s2_q ^ aux_prev_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            aux_s1_q   <= 1'b0;
            aux_s2_q   <= 1'b0;
            aux_prev_q <= 1'b0;
            state_q    <= ST_OFF;
            edge_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            sel_q      <= 1'b0;
            ok_q       <= 1'b0;
            fail_q     <= 1'b0;
`ifdef AUX_CLK_WATCHDOG_EN
            win_cnt_q  <= '0;
`endif
        end else begin
            aux_s1_q   <= aux_tgl;
            aux_s2_q   <= aux_s1_q;
            aux_prev_q <= aux_s2_q;
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            sel_q      <= sel_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
`ifdef AUX_CLK_WATCHDOG_EN
            win_cnt_q  <= win_cnt_d;
`endif
        end
    end

    // Next state; a dropped switch wins over lock, timeout and watchdog.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        sel_d      = 1'b0;
        ok_d       = 1'b0;
        fail_d     = 1'b0;
`ifdef AUX_CLK_WATCHDOG_EN
        win_cnt_d  = '0;
`endif
        case (state_q)
            ST_OFF: begin
                if (sw_deb) state_d = ST_START;
            end
            ST_START: begin
                edge_cnt_d = '0;
                tmo_cnt_d  = '0;
                state_d    = sw_deb ? ST_WAIT_LOCK : ST_OFF;
            end
            ST_WAIT_LOCK: begin
                if (aux_edge && (edge_cnt_q < EDGE_MAX)) edge_cnt_d = edge_cnt_q + EW'(1);
                if (tmo_cnt_q < TMO_MAX) tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (!sw_deb)                    state_d = ST_OFF;
                else if (edge_cnt_d >= EDGE_MAX) state_d = ST_RUN;
                else if (tmo_cnt_d >= TMO_MAX)   state_d = ST_FAIL;
            end
            ST_RUN: begin
`ifdef AUX_CLK_WATCHDOG_EN
                if (!aux_edge && (win_cnt_q < WIN_MAX)) win_cnt_d = win_cnt_q + WW'(1);
                if (!sw_deb)                    state_d = ST_OFF;
                else if (win_cnt_d >= WIN_MAX)  state_d = ST_FAIL;
`else
                if (!sw_deb) state_d = ST_OFF;
`endif
            end
            ST_FAIL: begin
                if (!sw_deb) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        sel_d  = (state_d == ST_START) || (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN);
        ok_d   = (state_d == ST_RUN);
        fail_d = (state_d == ST_FAIL);
    end

    assign sel_clk_aux = sel_q;
    assign aux_ok      = ok_q;
    assign aux_fail    = fail_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_aux_clk_ctrl.sv
// Self-checking bench for aux_clk_ctrl: directed table, corner sequences and
// randomized stimulus against a cycle-level reference model.
module tb_aux_clk_ctrl;

    localparam int DEB  = 16;
    localparam int LOCK = 8;
    localparam int TMO  = 1024;
    localparam int WIN  = 64;

    logic       clk;
    logic       nrst;
    logic       sw_en;
    logic       aux_tgl;
    logic       sel_clk_aux;
    logic       aux_ok;
    logic       aux_fail;
    logic [2:0] state_o;

    aux_clk_ctrl #(
        .DEB_CYCLES     (DEB),
        .LOCK_EDGES     (LOCK),
        .TIMEOUT_CYCLES (TMO),
        .WINDOW_CYCLES  (WIN)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .sw_en       (sw_en),
        .aux_tgl     (aux_tgl),
        .sel_clk_aux (sel_clk_aux),
        .aux_ok      (aux_ok),
        .aux_fail    (aux_fail),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // aux_tgl generator: toggle every aux_per cycles, 0 = held
    int aux_per = 3;
    int aux_ctr = 0;

    // Reference model: sample histories (index 0 = newest) and FSM bookkeeping
    int m_state;
    bit m_deb;
    int m_edges, m_wc, m_win;
    bit sw_hist[$];
    bit aux_hist[$];

    typedef struct {
        bit sw;
        int per;
        int cycles;
        int exp_state;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_deb   = 0;
        m_edges = 0;
        m_wc    = 0;
        m_win   = 0;
        sw_hist.delete();
        aux_hist.delete();
        for (int i = 0; i < DEB + 2; i++) sw_hist.push_back(1'b0);
        for (int i = 0; i < 3; i++) aux_hist.push_back(1'b0);
    endfunction

    // One clock edge of the model. The logic sees inputs two edges late;
    // sw_deb flips once the last DEB values it saw all disagree with it.
    function automatic void model_step(input bit sw, input bit aux);
        bit flip;
        bit edge_seen;
        int nxt;
        flip = 1'b1;
        for (int i = 1; i <= DEB; i++) if (sw_hist[i] == m_deb) flip = 1'b0;
        edge_seen = (aux_hist[1] != aux_hist[2]);
        nxt = m_state;
        case (m_state)
            0: if (m_deb) nxt = 1;
            1: begin
                m_edges = 0;
                m_wc    = 0;
                nxt     = m_deb ? 2 : 0;
            end
            2: begin
                if (!m_deb) nxt = 0;
                else begin
                    m_wc++;
                    if (edge_seen && m_edges < LOCK) m_edges++;
                    if (m_edges >= LOCK) begin
                        nxt   = 3;
                        m_win = 0;
                    end else if (m_wc >= TMO) nxt = 4;
                end
            end
            3: begin
                if (!m_deb) nxt = 0;
`ifdef AUX_CLK_WATCHDOG_EN
                else begin
                    m_win = edge_seen ? 0 : m_win + 1;
                    if (m_win >= WIN) nxt = 4;
                end
`endif
            end
            4: if (!m_deb) nxt = 0;
            default: nxt = 0;
        endcase
        m_state = nxt;
        if (flip) m_deb = !m_deb;
        sw_hist.push_front(sw);
        void'(sw_hist.pop_back());
        aux_hist.push_front(aux);
        void'(aux_hist.pop_back());
    endfunction

    // Advance one clock, step the model, compare, then move aux_tgl.
    task automatic cyc();
        logic [2:0] exp_o;
        @(posedge clk);
        if (!nrst) model_reset();
        else model_step(sw_en, aux_tgl);
        #1;
        exp_o[2] = (m_state >= 1 && m_state <= 3);
        exp_o[1] = (m_state == 3);
        exp_o[0] = (m_state == 4);
        chk("state_o", 32'(state_o), 32'(m_state));
        chk("sel_ok_fail", 32'({sel_clk_aux, aux_ok, aux_fail}), 32'(exp_o));
        if (aux_per > 0) begin
            aux_ctr++;
            if (aux_ctr >= aux_per) begin
                aux_ctr = 0;
                aux_tgl = ~aux_tgl;
            end
        end
    endtask

    initial begin
        #(20 * 90000);
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        bit found;
        int hold;

        vecs[0]  = '{1, 3, 70, 3};
        vecs[1]  = '{0, 3, 5, 3};
        vecs[2]  = '{1, 3, 40, 3};
        vecs[3]  = '{0, 3, 40, 0};
        vecs[4]  = '{1, 3, 5, 0};
        vecs[5]  = '{0, 3, 40, 0};
        vecs[6]  = '{1, 0, 1100, 4};
        vecs[7]  = '{1, 0, 50, 4};
        vecs[8]  = '{0, 0, 40, 0};
        vecs[9]  = '{1, 3, 70, 3};
        vecs[10] = '{1, 0, 100, 3};
        vecs[11] = '{0, 3, 40, 0};
`ifdef AUX_CLK_WATCHDOG_EN
        vecs[10].exp_state = 4;
`endif

        nrst    = 1'b1;
        sw_en   = 1'b1;
        aux_tgl = 1'b0;
        model_reset();
        #2 nrst = 1'b0;

        // Held in reset with the switch on
        repeat (100) cyc();
        chk("reset_sel", 32'(sel_clk_aux), 32'(0));
        sw_en = 1'b0;
        nrst  = 1'b1;
        repeat (5) cyc();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            sw_en   = vecs[i].sw;
            aux_per = vecs[i].per;
            if (aux_per == 0) aux_tgl = 1'b0;
            repeat (vecs[i].cycles) cyc();
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].exp_state));
        end

        // Latency from switch rise to oscillator enable
        sw_en   = 1'b1;
        aux_per = 3;
        found   = 1'b0;
        cnt     = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            cyc();
            if (sel_clk_aux) begin
                found = 1'b1;
                cnt   = i;
            end
        end
        n_vec++;
        if (!(cnt >= 18 && cnt <= 20)) begin
            n_err++;
            $display("FAIL sel_rise_latency: got %0d cycles expected 18..20", cnt);
        end
        for (int i = 0; i < 100 && state_o != 3'd3; i++) cyc();
        chk("lock_state", 32'(state_o), 32'(3));
        chk("lock_aux_ok", 32'(aux_ok), 32'(1));

        // Exact timeout with the aux clock dead
        sw_en = 1'b0;
        repeat (40) cyc();
        aux_per = 0;
        aux_tgl = 1'b0;
        sw_en   = 1'b1;
        for (int i = 0; i < 40 && state_o != 3'd2; i++) cyc();
        chk("enter_wait", 32'(state_o), 32'(2));
        cnt = 0;
        for (int i = 0; i < 1100 && state_o != 3'd4; i++) begin
            cyc();
            cnt++;
        end
        chk("timeout_cycles", 32'(cnt), 32'(TMO));
        chk("fail_sel", 32'(sel_clk_aux), 32'(0));
        chk("fail_flag", 32'(aux_fail), 32'(1));
        sw_en = 1'b0;
        for (int i = 0; i < 40 && state_o != 3'd0; i++) cyc();
        chk("fail_to_off", 32'(state_o), 32'(0));

        // Asynchronous reset in the middle of WAIT_LOCK
        sw_en   = 1'b1;
        aux_per = 3;
        for (int i = 0; i < 40 && state_o != 3'd2; i++) cyc();
        cyc();
        chk("pre_reset_wait", 32'(state_o), 32'(2));
        #5 nrst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_outs", 32'({sel_clk_aux, aux_ok, aux_fail, state_o}), 32'(0));
        repeat (3) cyc();
        nrst = 1'b1;
        for (int i = 0; i < 100 && state_o != 3'd3; i++) cyc();
        chk("relock_state", 32'(state_o), 32'(3));

        // Randomized stimulus against the model
        for (int r = 0; r < 60; r++) begin
            sw_en   = 1'($urandom_range(0, 1));
            hold    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20))
                                                  : int'($urandom_range(20, 120));
            aux_per = int'($urandom_range(0, 5));
            if (aux_per == 0) aux_tgl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                nrst = 1'b0;
                repeat (2) cyc();
                nrst = 1'b1;
            end
            repeat (hold) cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
